// File: rtl/reloj_pkg.sv
// Shared constants and FSM encoding for the BCD time-of-day core.
package reloj_pkg;

  localparam int unsigned MAX_SEG     = 59;
  localparam int unsigned MAX_MIN     = 59;
  localparam int unsigned MAX_HORA_24 = 23;
  localparam int unsigned MAX_HORA_12 = 12;

  // BCD digit widths: units, minute/second tens, hour tens
  localparam int unsigned W_UNI  = 4;
  localparam int unsigned W_DEC  = 3;
  localparam int unsigned W_HDEC = 2;

  typedef enum logic {
    CORRE  = 1'b0,
    AJUSTE = 1'b1
  } estado_t;

endpackage

// File: rtl/reloj_bcd_contador.sv
// Two-digit BCD counter wrapping MAX_D:MAX_U -> 00; carry flags the wrap step.
module contador_bcd_mod
  import reloj_pkg::*;
#(
  parameter int unsigned MAX_D = 5,
  parameter int unsigned MAX_U = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [W_UNI-1:0] unidades,
  output logic [W_DEC-1:0] decenas,
  output logic             carry
);

  logic en_maximo;

  assign en_maximo = (decenas == W_DEC'(MAX_D)) && (unidades == W_UNI'(MAX_U));

  // carry is combinational so the next digit pair steps on the same edge
  assign carry = en && en_maximo;

  // Digit registers: clear has priority, units carry into tens at 9
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unidades <= '0;
      decenas  <= '0;
    end else if (clr) begin
      unidades <= '0;
      decenas  <= '0;
    end else if (en) begin
      if (en_maximo) begin
        unidades <= '0;
        decenas  <= '0;
      end else if (unidades == W_UNI'(9)) begin
        unidades <= '0;
        decenas  <= decenas + W_DEC'(1);
      end else begin
        unidades <= unidades + W_UNI'(1);
      end
    end
  end

endmodule

// File: rtl/reloj_bcd.sv
// BCD HH:MM:SS timekeeping core with run/set modes.
// Build option: define FORMATO_12H_EN for 12-hour format with a pm output.
module reloj_bcd
  import reloj_pkg::*;
#(
  parameter int unsigned CICLOS_SEG = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              modo_ajuste,
  input  logic              inc_min,
  input  logic              inc_hora,
  output logic [W_UNI-1:0]  seg_u,
  output logic [W_DEC-1:0]  seg_d,
  output logic [W_UNI-1:0]  min_u,
  output logic [W_DEC-1:0]  min_d,
  output logic [W_UNI-1:0]  hora_u,
  output logic [W_HDEC-1:0] hora_d,
  output logic              pulso_minuto,
  output logic              en_ajuste
`ifdef FORMATO_12H_EN
  , output logic            pm
`endif
);

  localparam int unsigned PW = $clog2(CICLOS_SEG);

  estado_t         estado, estado_sig;
  logic [PW-1:0]   presc;
  logic            inc_min_q, inc_hora_q;
  logic            corre, tick, sube_min, sube_hora;
  logic            carry_seg, carry_min, en_min, en_hora;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= CORRE;
    else        estado <= estado_sig;
  end

  // Next state follows the mode level in either state
  always_comb begin
    estado_sig = estado;
    case (estado)
      CORRE:   if (modo_ajuste)  estado_sig = AJUSTE;
      AJUSTE:  if (!modo_ajuste) estado_sig = CORRE;
      default: estado_sig = CORRE;
    endcase
  end

  // Time only runs when we are in CORRE and staying there
  assign corre     = (estado == CORRE) && (estado_sig == CORRE);
  assign tick      = corre && (presc == PW'(CICLOS_SEG - 1));
  assign sube_min  = (estado == AJUSTE) && inc_min  && !inc_min_q;
  assign sube_hora = (estado == AJUSTE) && inc_hora && !inc_hora_q;
  assign en_min    = (tick && carry_seg) || sube_min;
  assign en_hora   = (tick && carry_seg && carry_min) || sube_hora;
  assign en_ajuste = (estado == AJUSTE);

  // Prescaler: counts in CORRE, held at 0 otherwise so each run starts a full second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      presc <= '0;
    else if (!corre) presc <= '0;
    else if (tick)   presc <= '0;
    else             presc <= presc + PW'(1);
  end

  // Button edge detectors and minute pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_min_q    <= 1'b0;
      inc_hora_q   <= 1'b0;
      pulso_minuto <= 1'b0;
    end else begin
      inc_min_q    <= inc_min;
      inc_hora_q   <= inc_hora;
      pulso_minuto <= tick && carry_seg;
    end
  end

  contador_bcd_mod #(.MAX_D(MAX_SEG / 10), .MAX_U(MAX_SEG % 10)) u_seg (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tick),
    .clr      (estado_sig == AJUSTE),
    .unidades (seg_u),
    .decenas  (seg_d),
    .carry    (carry_seg)
  );

  // Set-mode steps reuse the same wrap; the carry only matters on a tick
  contador_bcd_mod #(.MAX_D(MAX_MIN / 10), .MAX_U(MAX_MIN % 10)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_min),
    .clr      (1'b0),
    .unidades (min_u),
    .decenas  (min_d),
    .carry    (carry_min)
  );

`ifdef FORMATO_12H_EN
  // Hours 12,01..11,12; pm flips on every 11->12 step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hora_d <= W_HDEC'(MAX_HORA_12 / 10);
      hora_u <= W_UNI'(MAX_HORA_12 % 10);
      pm     <= 1'b0;
    end else if (en_hora) begin
      if (hora_d == W_HDEC'(MAX_HORA_12 / 10) && hora_u == W_UNI'(MAX_HORA_12 % 10)) begin
        hora_d <= '0;
        hora_u <= W_UNI'(1);
      end else if (hora_d == W_HDEC'(1) && hora_u == W_UNI'(1)) begin
        hora_u <= W_UNI'(2);
        pm     <= !pm;
      end else if (hora_u == W_UNI'(9)) begin
        hora_d <= W_HDEC'(1);
        hora_u <= '0;
      end else begin
        hora_u <= hora_u + W_UNI'(1);
      end
    end
  end
`else
  // Hours 00..23
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hora_d <= '0;
      hora_u <= '0;
    end else if (en_hora) begin
      if (hora_d == W_HDEC'(MAX_HORA_24 / 10) && hora_u == W_UNI'(MAX_HORA_24 % 10)) begin
        hora_d <= '0;
        hora_u <= '0;
      end else if (hora_u == W_UNI'(9)) begin
        hora_d <= hora_d + W_HDEC'(1);
        hora_u <= '0;
      end else begin
        hora_u <= hora_u + W_UNI'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_reloj_bcd.sv
// Self-checking bench for reloj_bcd against a seconds/minutes/hours arithmetic model.
module tb_reloj_bcd;

  localparam int unsigned CS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       modo_ajuste = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hora = 1'b0;
  logic [3:0] seg_u, min_u, hora_u;
  logic [2:0] seg_d, min_d;
  logic [1:0] hora_d;
  logic       pulso_minuto, en_ajuste;
  logic       pm;

  reloj_bcd #(.CICLOS_SEG(CS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .modo_ajuste  (modo_ajuste),
    .inc_min      (inc_min),
    .inc_hora     (inc_hora),
    .seg_u        (seg_u),
    .seg_d        (seg_d),
    .min_u        (min_u),
    .min_d        (min_d),
    .hora_u       (hora_u),
    .hora_d       (hora_d),
    .pulso_minuto (pulso_minuto),
    .en_ajuste    (en_ajuste)
`ifdef FORMATO_12H_EN
    , .pm         (pm)
`endif
  );

`ifndef FORMATO_12H_EN
  assign pm = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  int mh, mm, ms, presc;
  bit mpm, mpulse, mode_q, imp, ihp;

  logic [19:0] dut_t;
  assign dut_t = {hora_d, hora_u, min_d, min_u, seg_d, seg_u};

  function automatic logic [19:0] exp_t();
    return {2'(mh / 10), 4'(mh % 10), 3'(mm / 10), 4'(mm % 10), 3'(ms / 10), 4'(ms % 10)};
  endfunction

  function automatic void model_reset();
`ifdef FORMATO_12H_EN
    mh = 12;
`else
    mh = 0;
`endif
    mm = 0; ms = 0; presc = 0;
    mpm = 0; mpulse = 0; mode_q = 0; imp = 0; ihp = 0;
  endfunction

  function automatic void hr_inc();
`ifdef FORMATO_12H_EN
    if (mh == 11) begin mh = 12; mpm = !mpm; end
    else mh = (mh % 12) + 1;
`else
    mh = (mh + 1) % 24;
`endif
  endfunction

  function automatic void model_step();
    mpulse = 0;
    if (mode_q) begin
      if (inc_min && !imp)  mm = (mm + 1) % 60;
      if (inc_hora && !ihp) hr_inc();
    end
    if (modo_ajuste) begin
      ms = 0; presc = 0;
    end else if (!mode_q) begin
      if (presc == CS - 1) begin
        presc = 0;
        if (ms == 59) begin
          ms = 0; mpulse = 1;
          if (mm == 59) begin mm = 0; hr_inc(); end
          else mm = mm + 1;
        end else ms = ms + 1;
      end else presc = presc + 1;
    end
    mode_q = modo_ajuste; imp = inc_min; ihp = inc_hora;
  endfunction

  // One clock: advance the model with the inputs present at the edge, then settle
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic press(input bit a, input bit b);
    inc_min = a; inc_hora = b;
    cyc();
    inc_min = 0; inc_hora = 0;
    cyc();
  endtask

  task automatic run_until_sec(input int target);
    int n = 0;
    while (ms != target && n < 70 * CS) begin cyc(); n++; end
    n_cmp++;
    if (ms != target || dut_t !== exp_t()) begin
      n_fail++;
      $display("FAIL run_until_sec%0d: got %h required %h (waited %0d)", target, dut_t, exp_t(), n);
    end
  endtask

  // Enter set mode and step hours/minutes to the targets
  task automatic preload(input int h, input int m);
    int n = 0;
    modo_ajuste = 1; cyc();
    while (mh != h && n < 30) begin press(0, 1); n++; end
    n = 0;
    while (mm != m && n < 70) begin press(1, 0); n++; end
    modo_ajuste = 0; cyc();
  endtask

  task automatic test_reset();
    rst_n = 0; modo_ajuste = 0; inc_min = 0; inc_hora = 0;
    model_reset();
    cyc(); cyc();
    n_cmp++;
    if (dut_t !== exp_t() || pulso_minuto !== 0 || en_ajuste !== 0 || pm !== 0) begin
      n_fail++;
      $display("FAIL reset_values: got t=%h p=%b e=%b pm=%b required t=%h 0 0 0",
               dut_t, pulso_minuto, en_ajuste, pm, exp_t());
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) cyc();
    n_cmp++;
    if (seg_u !== 4'd1 || dut_t !== exp_t()) begin
      n_fail++;
      $display("FAIL first_second: got seg_u=%0d required 1", seg_u);
    end
    for (int i = 4; i < 40; i++) cyc();
    n_cmp++;
    if (seg_d !== 3'd1 || seg_u !== 4'd0 || dut_t !== exp_t()) begin
      n_fail++;
      $display("FAIL ten_seconds: got %0d%0d required 10", seg_d, seg_u);
    end
  endtask

  task automatic test_set_mode();
    int hold_h;
    run_until_sec(37);
    modo_ajuste = 1; cyc();
    n_cmp++;
    if (seg_u !== 0 || seg_d !== 0 || en_ajuste !== 1 || dut_t !== exp_t()) begin
      n_fail++;
      $display("FAIL enter_set: got t=%h en=%b required t=%h en=1", dut_t, en_ajuste, exp_t());
    end
    for (int i = 0; i < 3; i++) press(1, 0);
    n_cmp++;
    if (min_d !== 0 || min_u !== 4'd3 || dut_t !== exp_t()) begin
      n_fail++;
      $display("FAIL three_min_steps: got t=%h required t=%h (min 03)", dut_t, exp_t());
    end
    inc_min = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_cmp++;
      if (pulso_minuto !== 0) begin
        n_fail++;
        $display("FAIL pulse_in_set: got %b required 0", pulso_minuto);
      end
    end
    inc_min = 0; cyc();
    n_cmp++;
    if (min_u !== 4'd4 || dut_t !== exp_t()) begin
      n_fail++;
      $display("FAIL held_button: got min_u=%0d required 4", min_u);
    end
    while (mm != 59) press(1, 0);
    hold_h = mh;
    press(1, 0);
    n_cmp++;
    if (min_u !== 0 || min_d !== 0 || mh != hold_h || dut_t !== exp_t()) begin
      n_fail++;
      $display("FAIL min_wrap_set: got t=%h required t=%h", dut_t, exp_t());
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    while (mh != 5 && n < 30) begin press(0, 1); n++; end
    n = 0;
    while (mm != 10 && n < 70) begin press(1, 0); n++; end
    press(1, 1);
    n_cmp++;
    if (hora_d !== 0 || hora_u !== 4'd6 || min_d !== 3'd1 || min_u !== 4'd1 || dut_t !== exp_t()) begin
      n_fail++;
      $display("FAIL both_edges: got t=%h required 06:11 (%h)", dut_t, exp_t());
    end
    modo_ajuste = 0; cyc();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_cmp++;
      if (seg_u !== ((i == 4) ? 4'd1 : 4'd0) || en_ajuste !== 0) begin
        n_fail++;
        $display("FAIL exit_full_second: clk %0d got seg_u=%0d en=%b", i, seg_u, en_ajuste);
      end
    end
  endtask

  task automatic test_seconds_wrap();
    int pulses = 0;
    int m0;
    run_until_sec(59);
    m0 = mm;
    for (int i = 0; i < CS; i++) begin
      cyc();
      n_cmp++;
      if (pulso_minuto !== mpulse) begin
        n_fail++;
        $display("FAIL wrap_pulse: got %b required %b", pulso_minuto, mpulse);
      end
      pulses += int'(pulso_minuto);
    end
    n_cmp++;
    if (pulses != 1 || ms != 0 || mm != (m0 + 1) % 60 || dut_t !== exp_t()) begin
      n_fail++;
      $display("FAIL seconds_wrap: got t=%h pulses=%0d required t=%h pulses=1", dut_t, pulses, exp_t());
    end
  endtask

  task automatic test_full_wrap();
    int pulses = 0;
    bit pm0;
`ifdef FORMATO_12H_EN
    preload(11, 59);
`else
    preload(23, 59);
`endif
    run_until_sec(59);
    pm0 = mpm;
    for (int i = 0; i < CS; i++) begin cyc(); pulses += int'(pulso_minuto); end
    n_cmp++;
`ifdef FORMATO_12H_EN
    if (dut_t !== 20'h48000 || pm !== !pm0 || pulses != 1) begin
      n_fail++;
      $display("FAIL full_wrap: got t=%h pm=%b pulses=%0d required 48000 pm=%b 1", dut_t, pm, pulses, !pm0);
    end
`else
    if (dut_t !== 20'h0 || pulses != 1) begin
      n_fail++;
      $display("FAIL full_wrap: got t=%h pulses=%0d required 00000 1", dut_t, pulses);
    end
`endif
  endtask

  task automatic test_midrun_reset();
    preload(12, 34);
    run_until_sec(56);
    #2 rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_t !== exp_t() || pulso_minuto !== 0 || en_ajuste !== 0 || pm !== 0) begin
      n_fail++;
      $display("FAIL async_reset: got t=%h p=%b pm=%b required t=%h 0 0", dut_t, pulso_minuto, pm, exp_t());
    end
    cyc();
    rst_n = 1;
    cyc();
    n_cmp++;
    if (dut_t !== exp_t() || pulso_minuto !== 0) begin
      n_fail++;
      $display("FAIL after_reset: got t=%h required t=%h", dut_t, exp_t());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) modo_ajuste = !modo_ajuste;
      inc_min  = ($urandom_range(0, 3) == 0);
      inc_hora = ($urandom_range(0, 5) == 0);
      cyc();
      n_cmp++;
      if (dut_t !== exp_t() || pulso_minuto !== mpulse || en_ajuste !== mode_q
`ifdef FORMATO_12H_EN
          || pm !== mpm
`endif
         ) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got t=%h p=%b e=%b required t=%h p=%b e=%b",
                 i, dut_t, pulso_minuto, en_ajuste, exp_t(), mpulse, mode_q);
      end
    end
    modo_ajuste = 0; inc_min = 0; inc_hora = 0;
  endtask

  initial begin
    test_reset();
    test_set_mode();
    test_simultaneous();
    test_seconds_wrap();
    test_full_wrap();
    test_midrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reloj_bcd.md
Name: reloj_bcd

Overview:
- Timekeeping core of the alarm clock. Holds current time as BCD HH:MM:SS and advances it once per second from an internal prescaler.
- Provides a set mode in which minutes and hours are stepped by push-button pulses.
- Its BCD digits feed the downstream 2:1 display selector, which chooses between current time and alarm time.
- Its minute-boundary pulse feeds the alarm comparator.

Parameters:
- CICLOS_SEG, 50000000, clk cycles per second. Minimum 2; the bench uses 4.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- modo_ajuste  input  1  level: 1 = set mode, 0 = run mode
- inc_min  input  1  synchronous level from debouncer; each rising edge = one minute step
- inc_hora  input  1  synchronous level from debouncer; each rising edge = one hour step
- seg_u  output  4  seconds units (BCD)
- seg_d  output  3  seconds tens (0-5)
- min_u  output  4  minutes units (BCD)
- min_d  output  3  minutes tens (0-5)
- hora_u  output  4  hours units (BCD)
- hora_d  output  2  hours tens (0-2)
- pulso_minuto  output  1  one-cycle pulse on the 59->00 seconds wrap
- en_ajuste  output  1  1 while the FSM is in AJUSTE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - time 00:00:00, i.e. all digit outputs 0
  - pulso_minuto=0, en_ajuste=0
  - prescaler=0, FSM=CORRE
  - edge-detect registers=0
- All outputs are registered.
- Prescaler: counts 0..CICLOS_SEG-1 in CORRE only.
  - tick=1 in the cycle the count equals CICLOS_SEG-1; the count then wraps to 0.
  - The time updates on the clock edge that ends the tick cycle.
- FSM has two states:
  - CORRE->AJUSTE when modo_ajuste=1.
  - AJUSTE->CORRE when modo_ajuste=0.
  - Transitions are sampled every clk.
- CORRE:
  - On tick, seconds increment. 59 wraps to 00 with carry into minutes.
  - Minutes 59 wraps to 00 with carry into hours.
  - Hours 23 wraps to 00.
  - Units digits wrap 9->0 with carry to the tens digit.
  - inc_min and inc_hora are ignored.
- Entering AJUSTE: seconds clear to 00 and the prescaler clears to 0 on the transition edge. Both are held while in AJUSTE.
- AJUSTE:
  - A rising edge of inc_min (registered previous value 0, current 1) increments minutes modulo 60 with no carry into hours.
  - A rising edge of inc_hora increments hours modulo 24.
  - Both edges in the same cycle apply both increments.
  - A held button produces only one step.
- Exiting AJUSTE: the prescaler starts from 0, so the first second after exit is a full CICLOS_SEG cycles.
- pulso_minuto:
  - Asserts for exactly one cycle, coincident with the seconds update 59->00 in CORRE.
  - Never asserts in AJUSTE.
- rst_n low mid-operation, in either state: immediate return to the reset values. No pulse is emitted.
- Digit values are never outside their legal ranges. No illegal BCD is reachable.

Optional Feature:
- Macro FORMATO_12H_EN.
- Defined:
  - Hours run 12,01..11,12 with an extra output pm (1 bit, placed after en_ajuste).
  - Reset time is 12:00:00 with pm=0.
  - pm toggles when hours go 11->12, both on carry and on inc_hora.
  - hora_d is limited to 0-1.
- Undefined: 24-hour behaviour as above; the pm port is absent.

Decomposition:
- Package reloj_pkg:
  - MAX_SEG=59, MAX_MIN=59, MAX_HORA_24=23, MAX_HORA_12=12
  - FSM state encoding: CORRE=1'b0, AJUSTE=1'b1
  - BCD digit width constants
- One natural sub-module: contador_bcd_mod.
  - Two-digit BCD counter.
  - Parameters: maximum tens and units value.
  - Inputs: en, clr.
  - Outputs: unidades, decenas, carry.
  - Instanced for seconds and minutes. Hours use a custom wrap (23->00, or 12-hour rules).

Test Plan:
- Reset, CICLOS_SEG=4: hold rst_n=0, release -> 00:00:00. After 4 clks seg_u=1; after 40 clks seg_d=1, seg_u=0.
- Seconds wrap: run to 00:00:59, next tick -> 00:01:00. pulso_minuto=1 for exactly one cycle on that edge.
- Full wrap: preload to 23:59:59 via set mode plus 59 ticks. Next tick -> 00:00:00 with one pulso_minuto.
- Set mode: modo_ajuste=1 at 00:00:37 -> seconds=00, en_ajuste=1.
  - 3 inc_min rising edges -> 00:03:00.
  - inc_min held high 20 cycles -> still one step.
  - Minutes 59 plus one edge -> 00 with hours unchanged.
- Simultaneous edges: inc_min and inc_hora rise in the same cycle at 05:10 -> 06:11. Exit set mode -> first seg_u=1 exactly 4 clks later.
- Mid-run reset: assert rst_n=0 at 12:34:56 for 1 cycle, asynchronously between edges -> 00:00:00 immediately, pulso_minuto=0.
  - With FORMATO_12H_EN the same stimulus gives 12:00:00, pm=0.
  - With FORMATO_12H_EN, 11:59:59 plus tick -> 12:00:00 with pm toggled.
